instr_sequencer: RTL



---
 rtl/risc_pkg.sv | 93 +++++++++
 rtl/instr_sequencer_if.sv | 33 +++
 rtl/handshake_timer.sv | 29 ++
 rtl/instr_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared RISC core definitions: instruction IDs, ALU controls, sequencer states,
// PC/writeback mux encodings and the instruction-class helper used by the decoder and sequencer.
package risc_pkg;

    localparam logic [4:0] ID_ADD  = 5'd1;
    localparam logic [4:0] ID_SUB  = 5'd2;
    localparam logic [4:0] ID_MUL  = 5'd3;
    localparam logic [4:0] ID_DIV  = 5'd4;
    localparam logic [4:0] ID_REM  = 5'd5;
    localparam logic [4:0] ID_AND  = 5'd6;
    localparam logic [4:0] ID_OR   = 5'd7;
    localparam logic [4:0] ID_XOR  = 5'd8;
    localparam logic [4:0] ID_SLL  = 5'd9;
    localparam logic [4:0] ID_SRL  = 5'd10;
    localparam logic [4:0] ID_SLT  = 5'd11;
    localparam logic [4:0] ID_ADDI = 5'd12;
    localparam logic [4:0] ID_ANDI = 5'd13;
    localparam logic [4:0] ID_ORI  = 5'd14;
    localparam logic [4:0] ID_XORI = 5'd15;
    localparam logic [4:0] ID_SLLI = 5'd16;
    localparam logic [4:0] ID_SRLI = 5'd17;
    localparam logic [4:0] ID_LW   = 5'd18;
    localparam logic [4:0] ID_SW   = 5'd19;
    localparam logic [4:0] ID_JAL  = 5'd20;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_REM = 4'd10;

    typedef logic [2:0] seq_state_t;
    localparam seq_state_t ST_FETCH    = 3'd0;
    localparam seq_state_t ST_DECODE   = 3'd1;
    localparam seq_state_t ST_EXEC     = 3'd2;
    localparam seq_state_t ST_ALU_WAIT = 3'd3;
    localparam seq_state_t ST_MEM      = 3'd4;
    localparam seq_state_t ST_WB       = 3'd5;
    localparam seq_state_t ST_ERROR    = 3'd6;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4 = 2'b00,
        PC_SRC_JUMP  = 2'b01
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'b00,
        WB_SRC_MEM = 2'b01,
        WB_SRC_PC4 = 2'b10
    } wb_src_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_MULDIV,
        CLS_LOAD,
        CLS_STORE,
        CLS_JUMP
    } instr_class_t;

    typedef struct packed {
        logic    pc_we;
        pc_src_t pc_src;
        logic    ir_we;
        logic    mem_req;
        logic    mem_we;
        logic    mem_addr_src;
        logic    alu_src_b;
        logic    alu_start;
        logic    reg_we;
        wb_src_t wb_src;
    } ctrl_t;

    function automatic instr_class_t classify(input logic [4:0] id);
        instr_class_t cls;
        cls = CLS_ILLEGAL;
        if (id inside {ID_MUL, ID_DIV, ID_REM}) cls = CLS_MULDIV;
        else if (id >= ID_ADD && id <= ID_SLT) cls = CLS_RTYPE;
        else if (id >= ID_ADDI && id <= ID_SRLI) cls = CLS_ITYPE;
        else if (id == ID_LW) cls = CLS_LOAD;
        else if (id == ID_SW) cls = CLS_STORE;
        else if (id == ID_JAL) cls = CLS_JUMP;
        return cls;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control bus between the instruction sequencer (master) and the datapath (slave):
// decoder ID and handshakes towards the sequencer, strobes, selects and status flags back.
interface instr_sequencer_if;
    import risc_pkg::*;

    logic [4:0] instr_id;
    logic       mem_ready;
    logic       alu_done;
    logic       pc_we;
    pc_src_t    pc_src;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       alu_src_b;
    logic       alu_start;
    logic       reg_we;
    wb_src_t    wb_src;
    logic       illegal;
    logic       timeout;

    modport master (
        input  instr_id, mem_ready, alu_done,
        output pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_src,
               alu_src_b, alu_start, reg_we, wb_src, illegal, timeout
    );

    modport slave (
        output instr_id, mem_ready, alu_done,
        input  pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_src,
               alu_src_b, alu_start, reg_we, wb_src, illegal, timeout
    );
endinterface

// File: rtl/handshake_timer.sv
// Stall counter for handshake states: counts cycles without the awaited response and
// raises hit_o in the stalled cycle that exhausts the TIMEOUT_CYCLES budget.
module handshake_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign hit_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM for the RISC core.
// Define RISC_MULDIV_EN to sequence MUL/DIV/REM through the multi-cycle ALU; otherwise they trap as illegal.
module instr_sequencer
    import risc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_sequencer_if.master bus
);
    seq_state_t   state_q, state_d;
    logic [4:0]   cur_id_q, cur_id_d;
    logic         illegal_q, illegal_d;
    logic         timeout_q, timeout_d;
    instr_class_t dec_cls, cur_cls;
    logic         dec_legal, alu_done, handshake, wait_en, state_chg, hit;
    ctrl_t        ctrl, ctrl_o;

`ifdef RISC_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
    assign alu_done = bus.alu_done;
`else
    localparam bit MULDIV_EN = 1'b0;
    logic unused_alu_done;
    assign alu_done        = 1'b0;
    assign unused_alu_done = bus.alu_done;
`endif

    assign dec_cls   = classify(bus.instr_id);
    assign cur_cls   = classify(cur_id_q);
    assign dec_legal = (dec_cls != CLS_ILLEGAL) && (MULDIV_EN || dec_cls != CLS_MULDIV);
    assign handshake = (state_q == ST_ALU_WAIT) ? alu_done : bus.mem_ready;
    assign wait_en   = (state_q inside {ST_FETCH, ST_MEM, ST_ALU_WAIT}) && !handshake;
    assign state_chg = (state_d != state_q);

    handshake_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_chg),
        .en_i  (wait_en),
        .hit_o (hit)
    );

    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_FETCH:    if (bus.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                cur_id_d = bus.instr_id;
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d   = ST_ERROR;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                case (cur_cls)
                    CLS_MULDIV:          state_d = ST_ALU_WAIT;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_JUMP:            state_d = ST_FETCH;
                    default:             state_d = ST_WB;
                endcase
            end
            // Alu_done in the first ALU_WAIT cycle (latency 1) goes straight on to WB.
            ST_ALU_WAIT: if (alu_done) state_d = ST_WB;
            ST_MEM:      if (bus.mem_ready) state_d = (cur_cls == CLS_STORE) ? ST_FETCH : ST_WB;
            ST_WB:       state_d = ST_FETCH;
            ST_ERROR:    state_d = ST_ERROR;
            default:     state_d = ST_ERROR;
        endcase
        // hit only fires in a stalled cycle, so a handshake on the last allowed cycle wins.
        if (hit) begin
            state_d   = ST_ERROR;
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.ir_we  = 1'b1;
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_src = PC_SRC_PLUS4;
                end
            end
            ST_EXEC: begin
                case (cur_cls)
                    CLS_ITYPE, CLS_LOAD, CLS_STORE: ctrl.alu_src_b = 1'b1;
                    CLS_MULDIV: ctrl.alu_start = MULDIV_EN;
                    CLS_JUMP: begin
                        ctrl.reg_we = 1'b1;
                        ctrl.wb_src = WB_SRC_PC4;
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_src = PC_SRC_JUMP;
                    end
                    default: ctrl.alu_src_b = 1'b0;
                endcase
            end
            ST_MEM: begin
                ctrl.mem_req      = 1'b1;
                ctrl.mem_addr_src = 1'b1;
                ctrl.alu_src_b    = 1'b1;
                ctrl.mem_we       = (cur_cls == CLS_STORE);
            end
            ST_WB: begin
                ctrl.reg_we = 1'b1;
                ctrl.wb_src = (cur_cls == CLS_LOAD) ? WB_SRC_MEM : WB_SRC_ALU;
            end
            default: ctrl = '0;
        endcase
    end

    // Reset gates every strobe so a reset mid-access can never leak a write.
    assign ctrl_o = rst_n ? ctrl : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cur_id_q  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_id_q  <= cur_id_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_we        = ctrl_o.pc_we;
    assign bus.pc_src       = ctrl_o.pc_src;
    assign bus.ir_we        = ctrl_o.ir_we;
    assign bus.mem_req      = ctrl_o.mem_req;
    assign bus.mem_we       = ctrl_o.mem_we;
    assign bus.mem_addr_src = ctrl_o.mem_addr_src;
    assign bus.alu_src_b    = ctrl_o.alu_src_b;
    assign bus.alu_start    = ctrl_o.alu_start;
    assign bus.reg_we       = ctrl_o.reg_we;
    assign bus.wb_src       = ctrl_o.wb_src;
    assign bus.illegal      = illegal_q;
    assign bus.timeout      = timeout_q;
endmodule
